// File: rtl/tss_pkg.sv
// tss_pkg: shared field prime, dealer FSM states and modular add for the threshold-sharing blocks.
package tss_pkg;
  localparam logic [255:0] P_SECP = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  typedef enum logic [2:0] {IDLE, CHECK, MUL, ADD, EMIT, DONE, ERR} state_e;
  // Both operands must already be reduced below p.
  function automatic logic [255:0] mod_add(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] p);
    logic [256:0] s;
    logic [256:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = s - {1'b0, p};
    return (s >= {1'b0, p}) ? d[255:0] : s[255:0];
  endfunction
endpackage

// File: rtl/mod_mul_serial.sv
// mod_mul_serial: MSB-first double-and-add a*b mod P, one multiplier bit per cycle over 256 cycles.
module mod_mul_serial
  import tss_pkg::*;
#(
  parameter logic [255:0] P = P_SECP
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] a_i,
  input  logic [255:0] b_i,
  output logic [255:0] acc_o,
  output logic         done_o
);
  logic [255:0] acc_q, acc_d, dbl;
  logic [7:0]   bit_q;
  logic         run_q;
  always_comb begin
    dbl   = mod_add(acc_q, acc_q, P);
    acc_d = b_i[bit_q] ? mod_add(dbl, a_i, P) : dbl;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      bit_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= '0;
      bit_q <= 8'd255;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      bit_q <= bit_q - 8'd1;
      run_q <= bit_q != 8'd0;
    end
  end
  // High in the cycle whose closing edge performs the final (bit 0) step.
  assign done_o = run_q && bit_q == 8'd0;
  assign acc_o  = acc_q;
endmodule

// File: rtl/shamir_share_gen.sv
// shamir_share_gen: 2-of-N Shamir dealer; evaluates secret + coeff*x mod P at consecutive x
// and streams the shares over a valid/ready port.
module shamir_share_gen
  import tss_pkg::*;
#(
  parameter int           N_SHARES = 3,
  parameter logic [255:0] P        = P_SECP
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] secret,
  input  logic [255:0] coeff,
  input  logic [255:0] x_base,
  output logic [255:0] share_x,
  output logic [255:0] share_y,
  output logic         share_valid,
  input  logic         share_ready,
  output logic         busy,
  output logic         done,
  output logic         error
);
  state_e       state_q, state_d;
  logic [255:0] secret_q, coeff_q, xb_q, x_q, y_q, acc;
  logic [7:0]   cnt_q;
  logic         bad, mul_start, mul_done, hs;
  assign bad = secret_q >= P || coeff_q == '0 || coeff_q >= P || xb_q == '0 ||
               ({1'b0, xb_q} + 257'(N_SHARES - 1)) >= {1'b0, P};
  assign mul_start = state_q == CHECK && !bad;
  assign hs        = state_q == EMIT && share_ready;
  mod_mul_serial #(.P(P)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(mul_start),
    .a_i    (coeff_q),
    .b_i    (xb_q),
    .acc_o  (acc),
    .done_o (mul_done)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start ? CHECK : IDLE;
      CHECK: state_d = bad ? ERR : MUL;
      MUL:   state_d = mul_done ? ADD : MUL;
      ADD:   state_d = EMIT;
      EMIT:  state_d = (hs && cnt_q == 8'(N_SHARES - 1)) ? DONE : EMIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    share_valid = state_q == EMIT;
    busy        = state_q != IDLE;
    done        = state_q == DONE;
    error       = state_q == ERR;
    share_x     = x_q;
    share_y     = y_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      secret_q <= '0;
      coeff_q  <= '0;
      xb_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        secret_q <= secret;
        coeff_q  <= coeff;
        xb_q     <= x_base;
      end
      if (state_q == ADD) begin
        y_q   <= mod_add(acc, secret_q, P);
        x_q   <= xb_q;
        cnt_q <= '0;
      end
      // Next point on the line: y advances by the slope as x steps by one.
      if (hs) begin
        x_q   <= x_q + 256'd1;
        y_q   <= mod_add(y_q, coeff_q, P);
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_shamir_share_gen.sv
// tb_shamir_share_gen: directed checks of the Shamir dealer (latency, wrap, errors,
// backpressure, mid-run reset, and an arithmetic reference for a pseudo-random vector).
module tb_shamir_share_gen;
  localparam logic [255:0] PR = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, share_ready = 1'b0;
  logic [255:0] secret = '0, coeff = '0, x_base = '0;
  logic [255:0] share_x, share_y;
  logic share_valid, busy, done, error;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  shamir_share_gen #(.N_SHARES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .secret(secret), .coeff(coeff),
    .x_base(x_base), .share_x(share_x), .share_y(share_y), .share_valid(share_valid),
    .share_ready(share_ready), .busy(busy), .done(done), .error(error)
  );

  task automatic start_run(input logic [255:0] s, input logic [255:0] c, input logic [255:0] xb);
    @(posedge clk); #1;
    secret = s; coeff = c; x_base = xb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; secret = '1; coeff = '0; x_base = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!share_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({share_x, share_y, share_valid, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: x=%h y=%h v=%b b=%b d=%b e=%b want all 0",
               share_x, share_y, share_valid, busy, done, error);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    share_ready = 1'b1;
    start_run(256'd0, 256'd2, 256'd1);
    n_checks++;
    if ({busy, share_valid} !== 2'b10) begin
      n_fail++; $display("FAIL basic_check_state: busy,valid=%b want 10", {busy, share_valid});
    end
    wait_valid(n);
    n_checks++;
    if (n !== 258) begin n_fail++; $display("FAIL basic_latency: %0d edges want 258", n); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (share_x !== 256'(k + 1) || share_y !== 256'(2 * (k + 1)) || share_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_share%0d: x=%0h y=%0h v=%b want x=%0d y=%0d v=1",
                 k, share_x, share_y, share_valid, k + 1, 2 * (k + 1));
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if ({done, share_valid, busy} !== 3'b101) begin
      n_fail++; $display("FAIL basic_done: done,valid,busy=%b want 101", {done, share_valid, busy});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL basic_idle: done,busy=%b want 00", {done, busy});
    end
  endtask

  task automatic test_wrap;
    int n;
    share_ready = 1'b1;
    start_run(PR - 256'd1, 256'd1, 256'd1);
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (share_x !== 256'(k + 1) || share_y !== 256'(k)) begin
        n_fail++;
        $display("FAIL wrap_share%0d: x=%0h y=%0h want x=%0d y=%0d", k, share_x, share_y, k + 1, k);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: done=%b want 1", done); end
  endtask

  task automatic test_errors;
    logic [255:0] s[4], c[4], xb[4];
    s  = '{256'd5, PR, 256'd5, 256'd5};
    c  = '{256'd0, 256'd3, 256'd3, 256'd3};
    xb = '{256'd1, 256'd1, 256'd0, PR - 256'd2};
    share_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_run(s[i], c[i], xb[i]);
      n_checks++;
      if ({error, busy, share_valid} !== 3'b010) begin
        n_fail++; $display("FAIL err%0d_check: error,busy,valid=%b want 010", i, {error, busy, share_valid});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({error, busy, share_valid} !== 3'b110) begin
        n_fail++; $display("FAIL err%0d_pulse: error,busy,valid=%b want 110", i, {error, busy, share_valid});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({error, busy, share_valid} !== 3'b000) begin
        n_fail++; $display("FAIL err%0d_idle: error,busy,valid=%b want 000", i, {error, busy, share_valid});
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    share_ready = 1'b0;
    start_run(256'd7, 256'd5, 256'd10);
    wait_valid(n);
    n_checks++;
    if (n !== 258) begin n_fail++; $display("FAIL bp_latency: %0d edges want 258", n); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (share_valid !== 1'b1 || share_x !== 256'd10 || share_y !== 256'd57) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%b x=%0h y=%0h want v=1 x=a y=39", i, share_valid, share_x, share_y);
      end
    end
    share_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (share_x !== 256'(10 + k) || share_y !== 256'(57 + 5 * k)) begin
        n_fail++;
        $display("FAIL bp_share%0d: x=%0d y=%0d want x=%0d y=%0d", k, share_x, share_y, 10 + k, 57 + 5 * k);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: done=%b want 1", done); end
  endtask

  task automatic test_reset_mid_mul;
    int n;
    share_ready = 1'b1;
    start_run(256'd3, 256'd4, 256'd5);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({share_x, share_y, share_valid, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: x=%h y=%h v=%b b=%b d=%b e=%b want all 0",
               share_x, share_y, share_valid, busy, done, error);
    end
    rst_n = 1'b1;
    start_run(256'd1, 256'd1, 256'd1);
    wait_valid(n);
    n_checks++;
    if (n !== 258) begin n_fail++; $display("FAIL midrst_latency: %0d edges want 258", n); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (share_x !== 256'(k + 1) || share_y !== 256'(k + 2)) begin
        n_fail++;
        $display("FAIL midrst_share%0d: x=%0d y=%0d want x=%0d y=%0d", k, share_x, share_y, k + 1, k + 2);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_done: done=%b want 1", done); end
  endtask

  task automatic test_random;
    logic [255:0] s, c, xb, y0, y1;
    logic [511:0] t;
    int n;
    s = '0; c = '0; xb = '0;
    for (int i = 0; i < 8; i++) begin
      s  = {s[223:0], 32'($urandom())};
      c  = {c[223:0], 32'($urandom())};
      xb = {xb[223:0], 32'($urandom())};
    end
    s  = s % PR;
    c  = c % PR;
    if (c == '0) c = 256'd1;
    xb = xb % (PR - 256'd10) + 256'd1;
    y0 = '0; y1 = '0;
    share_ready = 1'b1;
    start_run(s, c, xb);
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      t = ({256'd0, s} + {256'd0, c} * {256'd0, xb + 256'(k)}) % {256'd0, PR};
      n_checks++;
      if (share_x !== xb + 256'(k) || share_y !== t[255:0]) begin
        n_fail++;
        $display("FAIL rand_share%0d: y=%h want %h", k, share_y, t[255:0]);
      end
      if (k == 0) y0 = share_y;
      if (k == 1) y1 = share_y;
      @(posedge clk); #1;
    end
    // Two-point interpolation at 0 with x1 - x0 = 1: secret = y0*x1 - y1*x0 mod P.
    t = ({256'd0, y0} * {256'd0, xb + 256'd1} % {256'd0, PR} + {256'd0, PR}
         - {256'd0, y1} * {256'd0, xb} % {256'd0, PR}) % {256'd0, PR};
    n_checks++;
    if (t[255:0] !== s) begin
      n_fail++; $display("FAIL rand_reconstruct: got %h want %h", t[255:0], s);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_errors();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shamir_share_gen.md
# shamir_share_gen

Dealer side of the 2-of-N Shamir threshold scheme over the secp256k1 base field. Takes a secret and one random degree-1 coefficient, evaluates y = secret + coeff·x mod P at N consecutive nonzero abscissae, and streams the (x, y) shares out over a valid/ready port. Any two emitted shares fed to `lagrange_interp` reconstruct the secret.

## Interface
- `N_SHARES`, default 3: shares emitted per run, legal range 2..255.
- `P`, default 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F: field prime.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `secret` in 256: value to split; must be < P.
- `coeff` in 256: random slope; must be nonzero and < P.
- `x_base` in 256: first abscissa; must be nonzero, and x_base+N_SHARES-1 must be < P.
- `share_x` out 256: abscissa of the current share.
- `share_y` out 256: ordinate of the current share.
- `share_valid` out 1: share_x/share_y hold a share.
- `share_ready` in 1: consumer accepts the share when valid && ready.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last share handshake.
- `error` out 1: one-cycle pulse on an illegal input; no shares are emitted.

## Operation
- States: IDLE, CHECK, MUL, ADD, EMIT, DONE, ERR.
- IDLE: on `start`, latch secret/coeff/x_base into internal registers, go to CHECK. Inputs may change after that edge.
- CHECK (1 cycle): error if secret ≥ P, coeff == 0, coeff ≥ P, x_base == 0, or x_base+N_SHARES-1 ≥ P. Compute the last check with 257-bit width. Error goes to ERR; otherwise clear acc and go to MUL.
- MUL (256 cycles): MSB-first double-and-add of coeff·x_base. Each cycle: acc ← 2·acc mod P, then acc ← acc + coeff mod P if the current x_base bit is 1. Bit counter runs 255→0.
- ADD (1 cycle): y ← acc + secret mod P; x ← x_base; count ← 0. Go to EMIT.
- EMIT: `share_valid` = 1, share_x = x, share_y = y. On a handshake: x ← x+1, y ← y + coeff mod P, count ← count+1. On the handshake where count == N_SHARES-1, go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- ERR: `error` = 1 for one cycle, then IDLE.
- Modular add: both operands < P. Form a 257-bit sum s; the result is s−P if s ≥ P, else s. The result is always < P.
- `start` outside IDLE is ignored.

## Timing
- Reset values: share_x = 0, share_y = 0, share_valid = 0, busy = 0, done = 0, error = 0; state = IDLE; all internal registers cleared.
- Reset asserted in any state, including mid-MUL or mid-EMIT, returns to IDLE on the next edge and aborts the run. Partially emitted shares are not retracted.
- Latency, with start sampled at edge T:
  - CHECK at T+1.
  - MUL over edges T+2..T+257.
  - ADD at T+258.
  - `share_valid` is first high in the cycle after edge T+258.
  - The error path pulses `error` in the cycle after edge T+1.
- With `share_ready` held high, one share per cycle. `done` is high in the cycle after the final handshake.
- Under backpressure, share_x/share_y stay stable while valid && !ready. `share_valid` never drops without a handshake, except on reset.
- `busy` is high from the cycle after the start edge through the DONE/ERR cycle.

## Structure
- Shared package `tss_pkg`: the P constant (shared with `lagrange_interp`), the state enum, and the mod_add function (257-bit compare/subtract).
- One sub-module, `mod_mul_serial`: the MUL datapath with start/done and the 256-cycle bit counter. It is reusable by later reconstruction-side multipliers.

## Test plan
- secret=0, coeff=2, x_base=1, N=3, ready high → shares (1,2), (2,4), (3,6). Any pair through `lagrange_interp` yields 0.
- Wrap: secret=P−1, coeff=1, x_base=1 → y = 0, 1, 2. x = 1, 2, 3.
- Error cases → `error` pulses 2 cycles after start, with no share_valid:
  - coeff=0
  - secret=P
  - x_base=0
  - x_base=P−2 with N=3
- Backpressure: hold ready low for 5 cycles after the first valid → share_x/share_y unchanged, and 3 shares still arrive in order.
- Reset at cycle 100 of MUL → all outputs at reset values next cycle. A new start then completes normally.
- Random secret/coeff/x_base < P, N=5 → each y matches a reference model. Any pair reconstructs the secret in `lagrange_interp`.
